// File: rtl/alu_sched_pkg.sv
// Shared constants for the ALU scheduler family: state encoding, flag bit
// positions inside a response flag vector, and default data-path widths.
package alu_sched_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int OPW_DEF   = 3;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_OVF   = 2;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to prio.
// Purely combinational so it can be reused inside wider arbiters.
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic prio,
    output logic grant_valid,
    output logic grant_id
);

    assign grant_valid = valid0 | valid1;
    assign grant_id    = (valid0 && valid1) ? prio : valid1;

endmodule

// File: rtl/alu_rr_arbiter.sv
// Time-shares one combinational ALU between two requesters, one operation in
// flight at a time, round-robin between them.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. Valid never waits on ready; ready may depend on valid. Request payload
// is sampled only on the transfer edge. The response payload is meaningful
// only while its valid is high.
module alu_rr_arbiter
    import alu_sched_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int OPW   = OPW_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_out,
    output logic [2:0]       rsp0_flags,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_out,
    output logic [2:0]       rsp1_flags,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    output logic             busy,
    output logic [1:0]       fsm_state
);

    logic [1:0]       state;
    logic             gnt_id;
    logic             prio;
    logic [WIDTH-1:0] res_out;
    logic [2:0]       res_flags;
    logic             grant_valid;
    logic             grant_id;
    logic             idle;
    logic             rsp_sel_ready;

    rr_arb2 u_arb (
        .valid0      (req0_valid),
        .valid1      (req1_valid),
        .prio        (prio),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Gating with reset keeps both readys low while reset is held, even in IDLE.
    assign idle       = (state == IDLE) && reset;
    assign req0_ready = idle && grant_valid && !grant_id;
    assign req1_ready = idle && grant_valid && grant_id;

    assign rsp0_valid    = (state == RESP) && !gnt_id;
    assign rsp1_valid    = (state == RESP) && gnt_id;
    assign rsp_sel_ready = gnt_id ? rsp1_ready : rsp0_ready;

    assign rsp0_out   = res_out;
    assign rsp0_flags = res_flags;
    assign rsp1_out   = res_out;
    assign rsp1_flags = res_flags;

    assign busy      = (state != IDLE);
    assign fsm_state = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            gnt_id    <= 1'b0;
            prio      <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            res_out   <= '0;
            res_flags <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        gnt_id <= grant_id;
                        alu_a  <= grant_id ? req1_a  : req0_a;
                        alu_b  <= grant_id ? req1_b  : req0_b;
                        alu_op <= grant_id ? req1_op : req0_op;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    res_out              <= alu_out;
                    res_flags[FLAG_OVF]   <= alu_overflow;
                    res_flags[FLAG_CARRY] <= alu_carry;
                    res_flags[FLAG_ZERO]  <= alu_zero;
                    state                <= RESP;
                end
                RESP: begin
                    // Priority moves only when a response completes.
                    if (rsp_sel_ready) begin
                        prio  <= ~gnt_id;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: directed scenarios then random traffic, checked
// against a transaction-level model with per-requester expected-result queues.
module tb_alu_rr_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic       v [0:1];
  logic [3:0] a [0:1];
  logic [3:0] b [0:1];
  logic [2:0] op [0:1];
  logic       rr [0:1];
  logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
  logic [3:0] rsp0_out, rsp1_out, alu_a, alu_b, alu_out;
  logic [2:0] rsp0_flags, rsp1_flags, alu_op;
  logic       alu_zero, alu_carry, alu_overflow;
  logic [1:0] fsm_state;

  int n_cmp = 0;
  int n_fail = 0;

  // model state
  bit         m_pend, m_owner, m_age, m_prio;
  logic [3:0] m_la, m_lb;
  logic [2:0] m_lop;
  logic [6:0] exp_q0[$];
  logic [6:0] exp_q1[$];
  int         grant_log[$];
  bit         acc [0:1];

  always #5 clock = ~clock;

  function automatic logic [6:0] alu_f(input logic [3:0] x, input logic [3:0] y, input logic [2:0] o);
    logic [4:0] s;
    logic [3:0] r;
    logic c, ov;
    s = '0; r = '0; c = 1'b0; ov = 1'b0;
    case (o)
      3'd0: begin s = {1'b0, x} + {1'b0, y}; r = s[3:0]; c = s[4]; ov = (x[3] == y[3]) && (r[3] != x[3]); end
      3'd1: begin s = {1'b0, x} - {1'b0, y}; r = s[3:0]; c = s[4]; ov = (x[3] != y[3]) && (r[3] != x[3]); end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      default: r = ~x;
    endcase
    return {ov, c, (r == 4'd0), r};
  endfunction

  assign {alu_overflow, alu_carry, alu_zero, alu_out} = alu_f(alu_a, alu_b, alu_op);

  alu_rr_arbiter dut (
    .clock(clock), .reset(reset),
    .req0_valid(v[0]), .req0_ready(req0_ready), .req0_a(a[0]), .req0_b(b[0]), .req0_op(op[0]),
    .req1_valid(v[1]), .req1_ready(req1_ready), .req1_a(a[1]), .req1_b(b[1]), .req1_op(op[1]),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rr[0]), .rsp0_out(rsp0_out), .rsp0_flags(rsp0_flags),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rr[1]), .rsp1_out(rsp1_out), .rsp1_flags(rsp1_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .busy(busy), .fsm_state(fsm_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {grant_valid, grant_id} from the arbitration rule
  function automatic logic [1:0] model_grant();
    if (v[0] && v[1]) return {1'b1, m_prio};
    if (v[1]) return 2'b11;
    if (v[0]) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_clear();
    m_pend = 0; m_owner = 0; m_age = 0; m_prio = 0;
    m_la = '0; m_lb = '0; m_lop = '0;
    exp_q0.delete(); exp_q1.delete();
    acc[0] = 0; acc[1] = 0;
  endtask

  task automatic sample();
    logic [1:0] g;
    bit e0, e1;
    #1;
    g = model_grant();
    e0 = m_pend && m_age && (m_owner == 1'b0);
    e1 = m_pend && m_age && (m_owner == 1'b1);
    chk("busy", 32'(busy), 32'(m_pend));
    chk("req0_ready", 32'(req0_ready), 32'(!m_pend && g[1] && !g[0]));
    chk("req1_ready", 32'(req1_ready), 32'(!m_pend && g[1] && g[0]));
    chk("rsp0_valid", 32'(rsp0_valid), 32'(e0));
    chk("rsp1_valid", 32'(rsp1_valid), 32'(e1));
    chk("alu_inputs", 32'({alu_a, alu_b, alu_op}), 32'({m_la, m_lb, m_lop}));
    if (e0) chk("rsp0_data", 32'({rsp0_flags, rsp0_out}), 32'(exp_q0.size() > 0 ? exp_q0[0] : 7'h7f));
    if (e1) chk("rsp1_data", 32'({rsp1_flags, rsp1_out}), 32'(exp_q1.size() > 0 ? exp_q1[0] : 7'h7f));
  endtask

  task automatic tick();
    logic [1:0] g;
    g = model_grant();
    acc[0] = 0; acc[1] = 0;
    if (!m_pend) begin
      if (g[1]) begin
        m_pend = 1; m_owner = g[0]; m_age = 0;
        m_la = a[g[0]]; m_lb = b[g[0]]; m_lop = op[g[0]];
        if (g[0]) exp_q1.push_back(alu_f(a[1], b[1], op[1]));
        else      exp_q0.push_back(alu_f(a[0], b[0], op[0]));
        grant_log.push_back(int'(g[0]));
        acc[g[0]] = 1;
      end
    end else if (!m_age) begin
      m_age = 1;
    end else if (rr[m_owner]) begin
      if (m_owner) void'(exp_q1.pop_front());
      else         void'(exp_q0.pop_front());
      m_pend = 0;
      m_prio = !m_owner;
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  // Asserted mid-cycle with both valids high so the forced-low readys are observable.
  task automatic do_reset();
    v[0] = 1; v[1] = 1;
    reset = 1'b0;
    #1;
    chk("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
    chk("rst_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_state", 32'(fsm_state), 32'd0);
    chk("rst_alu", 32'({alu_a, alu_b, alu_op}), 32'd0);
    chk("rst_rsp_data", 32'({rsp0_flags, rsp0_out, rsp1_flags, rsp1_out}), 32'd0);
    @(posedge clock);
    @(negedge clock);
    model_clear();
    v[0] = 0; v[1] = 0;
    reset = 1'b1;
  endtask

  task automatic rand_req(input int i);
    a[i] = 4'($urandom_range(0, 15));
    b[i] = 4'($urandom_range(0, 15));
    op[i] = 3'($urandom_range(0, 7));
  endtask

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin v[i] = 0; a[i] = '0; b[i] = '0; op[i] = '0; rr[i] = 0; end
    model_clear();
    @(negedge clock);
    do_reset();

    // single op on requester 0: 3 + 4
    rr[0] = 1; rr[1] = 1;
    v[0] = 1; a[0] = 4'd3; b[0] = 4'd4; op[0] = 3'd0;
    sample(); chk("single_ready_c0", 32'(req0_ready), 32'd1); tick();
    v[0] = 0;
    sample(); chk("single_busy_c1", 32'(busy), 32'd1); tick();
    sample();
    chk("single_valid_c2", 32'(rsp0_valid), 32'd1);
    chk("single_out", 32'(rsp0_out), 32'd7);
    chk("single_flags", 32'(rsp0_flags), 32'd0);
    tick();
    sample(); chk("single_idle_c3", 32'(busy), 32'd0); tick();

    // carry/zero on requester 1: F + 1
    v[1] = 1; a[1] = 4'hF; b[1] = 4'h1; op[1] = 3'd0;
    sample(); tick();
    v[1] = 0;
    sample(); tick();
    sample();
    chk("cz_valid", 32'(rsp1_valid), 32'd1);
    chk("cz_out", 32'(rsp1_out), 32'd0);
    chk("cz_flags", 32'(rsp1_flags), 32'b011);
    chk("cz_rsp0_quiet", 32'(rsp0_valid), 32'd0);
    tick();
    sample(); tick();

    // reset while the accepted op is in ISSUE; it must never respond
    v[0] = 1; a[0] = 4'd5; b[0] = 4'd6; op[0] = 3'd0;
    sample(); tick();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      sample(); chk("dropped_no_rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0); tick();
    end

    // fairness: both continuously valid, six grants must alternate from 0
    grant_log.delete();
    v[0] = 1; v[1] = 1; rand_req(0); rand_req(1);
    for (int k = 0; k < 60 && grant_log.size() < 6; k++) begin
      sample(); tick();
      for (int i = 0; i < 2; i++) if (acc[i]) rand_req(i);
    end
    v[0] = 0; v[1] = 0;
    for (int k = 0; k < 4; k++) begin sample(); tick(); end
    chk("fair_count", 32'(grant_log.size()), 32'd6);
    for (int k = 0; k < 6 && k < grant_log.size(); k++)
      chk($sformatf("fair_grant_%0d", k), 32'(grant_log[k]), 32'(k % 2));

    // backpressure on rsp0 for 5 RESP cycles with both requesters waiting
    v[0] = 1; rand_req(0); rr[0] = 0;
    sample(); tick();
    v[0] = 0;
    sample(); tick();
    v[0] = 1; v[1] = 1; rand_req(0); rand_req(1);
    for (int k = 0; k < 5; k++) begin
      sample(); chk("bp_no_accept", 32'({req0_ready, req1_ready}), 32'd0); tick();
    end
    rr[0] = 1;
    sample(); chk("bp_handshake_ready", 32'({req0_ready, req1_ready}), 32'd0); tick();
    sample(); chk("bp_next_accept", 32'(req1_ready), 32'd1); tick();
    v[0] = 0; v[1] = 0;
    for (int k = 0; k < 4; k++) begin sample(); tick(); end

    // random traffic: valid held until accepted, random response backpressure
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (!(v[i] && !acc[i])) begin
          v[i] = ($urandom_range(0, 3) != 0);
          rand_req(i);
        end
        rr[i] = ($urandom_range(0, 2) != 0);
      end
      sample(); tick();
    end
    v[0] = 0; v[1] = 0; rr[0] = 1; rr[1] = 1;
    for (int k = 0; k < 8; k++) begin sample(); tick(); end
    chk("drain_q0", 32'(exp_q0.size()), 32'd0);
    chk("drain_q1", 32'(exp_q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
Two-requester scheduler that time-shares the single combinational 4-bit ALU (A, B, op_type, out, zero/carry/overflow flags).
Each requester issues an operation through a valid/ready request channel and receives the result and flags through a valid/ready response channel.
Arbitration is round-robin with one operation in flight at a time.
The block sits between the switch/debug front end or future requesters and the ALU instance.

Parameters:
WIDTH, 4, operand/result width; matches the ALU data path.
OPW, 3, op-type width; op codes are opaque to this block and passed through unchanged.

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
req0_valid  in  1  requester 0 operation valid
req0_ready  out  1  requester 0 operation accepted this cycle
req0_a  in  WIDTH  requester 0 operand A
req0_b  in  WIDTH  requester 0 operand B
req0_op  in  OPW  requester 0 op type
req1_valid / req1_ready / req1_a / req1_b / req1_op  same as requester 0, for requester 1
rsp0_valid  out  1  result for requester 0 available
rsp0_ready  in  1  requester 0 consumes result
rsp0_out  out  WIDTH  ALU result
rsp0_flags  out  3  {overflow, carry, zero}
rsp1_valid / rsp1_ready / rsp1_out / rsp1_flags  same, for requester 1
alu_a  out  WIDTH  registered operand A to ALU
alu_b  out  WIDTH  registered operand B to ALU
alu_op  out  OPW  registered op type to ALU
alu_out  in  WIDTH  ALU result
alu_zero / alu_carry / alu_overflow  in  1 each  ALU flags
busy  out  1  high whenever state != IDLE

Behaviour:
- FSM states: IDLE, ISSUE, RESP. Registers: state, gnt_id (1b), prio (1b), alu_a/b/op, res_out, res_flags.
- Reset (asynchronous assert, any state):
  - state=IDLE, prio=0, gnt_id=0.
  - alu_a/b/op=0, res_out=0, res_flags=0.
  - All ready/valid outputs 0, busy=0.
  - Any in-flight operation is dropped and produces no response.
- IDLE grant rule (combinational from the valids):
  - Only reqX_valid high -> grant X.
  - Both high -> grant prio.
  - Neither high -> no grant.
- IDLE handshake:
  - reqX_ready = (state==IDLE) && grant==X. It may depend on valids; valid never depends on ready.
  - On reqX_valid && reqX_ready: latch a/b/op into alu_a/b/op, set gnt_id=X, go to ISSUE.
- ISSUE (exactly 1 cycle): the ALU sees stable registered inputs. At the end of the cycle, capture alu_out -> res_out and {alu_overflow, alu_carry, alu_zero} -> res_flags, then go to RESP.
- RESP:
  - rsp[gnt_id]_valid=1; the other rsp_valid=0.
  - rspX_out and rspX_flags always show res_out and res_flags, and are only meaningful while rspX_valid is high.
  - Hold until rsp[gnt_id]_ready. On that handshake: prio = ~gnt_id, state=IDLE.
  - A response stalled indefinitely blocks both requesters (no timeout).
- Latency and throughput:
  - Request accepted at edge t, result captured at edge t+1, rsp_valid high in the cycle after t+1.
  - With rsp_ready tied high, the minimum issue interval per operation is 3 cycles.
- Fairness:
  - With both requesters continuously valid, grants strictly alternate 0,1,0,1...
  - prio updates only on response completion, never on an idle cycle.
- alu_a/b/op hold their last value outside ISSUE; no re-issue occurs.
- Protocol requirement on requesters: operands are stable while valid and not ready. The block samples only on handshake.
- Simultaneous events: the response handshake and a new request in the same cycle cannot overlap. The new request is accepted in the following IDLE cycle.
- Width rules: no arithmetic in this block; all data paths are pure registers/muxes of WIDTH/OPW bits.

Decomposition:
- Shared package alu_sched_pkg:
  - state encoding IDLE=2'd0, ISSUE=2'd1, RESP=2'd2
  - flag bit indices FLAG_ZERO=0, FLAG_CARRY=1, FLAG_OVF=2
  - default WIDTH/OPW constants
- One natural sub-module: rr_arb2. Inputs: two valids, prio. Outputs: grant_valid, grant_id. Purely combinational, reused by future multi-requester blocks.

Test Plan:
- The bench ALU model uses op 3'b000 = A+B, with flags computed as 4-bit add.
- Reset mid-ISSUE: req0 accepted, reset asserted in ISSUE -> all outputs 0 immediately; after release, no rsp0_valid ever appears for the dropped op.
- Single op: req0 a=3, b=4, op=0, rsp0_ready=1 -> req0_ready in cycle 0; rsp0_valid in cycle 2 with out=7, flags=3'b000; busy high for cycles 1-2.
- Carry/zero: req1 a=4'hF, b=4'h1, op=0 -> rsp1_out=0, rsp1_flags={ovf=0, carry=1, zero=1}; rsp0_valid stays 0.
- Fairness: both valid continuously for 6 ops -> grant order 0,1,0,1,0,1; each response is routed only to its own rsp port.
- Backpressure: rsp0_ready low for 5 cycles in RESP -> rsp0_valid and out held stable, req0/req1_ready stay 0, alu_* unchanged; the new request is accepted the cycle after the handshake.
